// File: rtl/machine_trap_sequencer.sv
// Machine-mode trap entry/return sequencer: arbitrates interrupts, exceptions, ECALL/EBREAK and MRET.
// Optional interrupt support is enabled with the MTS_INTERRUPT_EN macro.
module machine_trap_sequencer #(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic [4:0] opcode_6_to_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs1_adder_in,
  input  logic [4:0] rs2_adder_in,
  input  logic [4:0] rd_adder_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       eirq_in,
  input  logic       tirq_in,
  input  logic       sirq_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       trap_taken_out,
  output logic       set_epc_out,
  output logic       set_cause_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic       misaligned_exception_out,
  output logic [1:0] state_out
);

  // State encoding doubles as the PC source select.
  localparam logic [1:0] S_RESET       = 2'b00;
  localparam logic [1:0] S_OPERATING   = 2'b01;
  localparam logic [1:0] S_TRAP_TAKEN  = 2'b10;
  localparam logic [1:0] S_TRAP_RETURN = 2'b11;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          is_system, base_zero, ecall, ebreak, mret;
  logic          exception, irq, trap, operating;
  logic          nxt_ie;
  logic [3:0]    nxt_cause;

  assign is_system = (opcode_6_to_2_in == 5'b11100);
  assign base_zero = (rs1_adder_in == 5'd0) && (rd_adder_in == 5'd0) && (funct3_in == 3'd0);
  assign ecall     = is_system && base_zero && (rs2_adder_in == 5'd0) && (funct7_in == 7'd0);
  assign ebreak    = is_system && base_zero && (rs2_adder_in == 5'd1) && (funct7_in == 7'd0);
  assign mret      = is_system && base_zero && (rs2_adder_in == 5'd2) && (funct7_in == 7'b0011000);
  assign exception = illegal_instr_in | misaligned_instr_in | misaligned_load_in | misaligned_store_in;

`ifdef MTS_INTERRUPT_EN
  logic eip, sip, tip;
  assign eip = meie_in & (eirq_in | meip_in);
  assign sip = msie_in & (sirq_in | msip_in);
  assign tip = mtie_in & (tirq_in | mtip_in);
  assign irq = mie_in & (eip | sip | tip);
`else
  logic unused_irq;
  assign unused_irq = ^{mie_in, meie_in, mtie_in, msie_in, eirq_in, tirq_in, sirq_in,
                        meip_in, mtip_in, msip_in};
  assign irq = 1'b0;
`endif

  assign trap = irq | exception | ecall | ebreak;

  // Interrupts outrank every synchronous cause.
  always_comb begin
    nxt_ie    = 1'b0;
    nxt_cause = 4'd0;
`ifdef MTS_INTERRUPT_EN
    if (irq) begin
      nxt_ie = 1'b1;
      if (eip)      nxt_cause = 4'd11;
      else if (sip) nxt_cause = 4'd3;
      else          nxt_cause = 4'd7;
    end else
`endif
    if (illegal_instr_in)         nxt_cause = 4'd2;
    else if (misaligned_instr_in) nxt_cause = 4'd0;
    else if (ecall)               nxt_cause = 4'd11;
    else if (ebreak)              nxt_cause = 4'd3;
    else if (misaligned_store_in) nxt_cause = 4'd6;
    else if (misaligned_load_in)  nxt_cause = 4'd4;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                    <= S_RESET;
      cnt                      <= '0;
      cause_out                <= 4'd0;
      i_or_e_out               <= 1'b0;
      misaligned_exception_out <= 1'b0;
    end else begin
      misaligned_exception_out <= misaligned_instr_in | misaligned_load_in | misaligned_store_in;
      case (state)
        S_RESET: state <= S_OPERATING;
        S_OPERATING: begin
          if (trap) begin
            state      <= S_TRAP_TAKEN;
            cnt        <= CNT_LOAD;
            cause_out  <= nxt_cause;
            i_or_e_out <= nxt_ie;
          end else if (mret) begin
            state <= S_TRAP_RETURN;
            cnt   <= CNT_LOAD;
          end
        end
        default: begin
          if (cnt == '0) state <= S_OPERATING;
          else           cnt   <= cnt - 1'b1;
        end
      endcase
    end
  end

  assign operating       = (state == S_OPERATING);
  assign state_out       = state;
  assign pc_src_out      = state;
  assign flush_out       = ~operating;
  assign instret_inc_out = operating;
  assign trap_taken_out  = operating & trap;
  assign set_epc_out     = operating & trap;
  assign set_cause_out   = operating & trap;
  assign mie_clear_out   = operating & trap;
  assign mie_set_out     = operating & ~trap & mret;

endmodule

// File: tb/tb_machine_trap_sequencer.sv
// Directed bench for machine_trap_sequencer with an expected-value queue and immediate assertions.
module tb_machine_trap_sequencer;

`ifdef MTS_INTERRUPT_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst3 = 1'b1;
  logic       illegal, mis_instr, mis_load, mis_store;
  logic [4:0] opcode, rs1, rs2, rd;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       mie, meie, mtie, msie, eirq, tirq, sirq, meip, mtip, msip;

  logic [1:0] pc_a, st_a, pc_b, st_b;
  logic       fl_a, tt_a, se_a, sc_a, mc_a, ms_a, ir_a, ie_a, mx_a;
  logic       fl_b, tt_b, se_b, sc_b, mc_b, ms_b, ir_b, ie_b, mx_b;
  logic [3:0] ca_a, ca_b;
  logic [15:0] obs_a, obs_b;

  logic [15:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  machine_trap_sequencer #(.FLUSH_CYCLES(1)) dut (
    .clk_in(clk), .rst_in(rst),
    .illegal_instr_in(illegal), .misaligned_instr_in(mis_instr),
    .misaligned_load_in(mis_load), .misaligned_store_in(mis_store),
    .opcode_6_to_2_in(opcode), .funct3_in(funct3), .funct7_in(funct7),
    .rs1_adder_in(rs1), .rs2_adder_in(rs2), .rd_adder_in(rd),
    .mie_in(mie), .meie_in(meie), .mtie_in(mtie), .msie_in(msie),
    .eirq_in(eirq), .tirq_in(tirq), .sirq_in(sirq),
    .meip_in(meip), .mtip_in(mtip), .msip_in(msip),
    .pc_src_out(pc_a), .flush_out(fl_a), .trap_taken_out(tt_a),
    .set_epc_out(se_a), .set_cause_out(sc_a), .mie_clear_out(mc_a),
    .mie_set_out(ms_a), .instret_inc_out(ir_a), .i_or_e_out(ie_a),
    .cause_out(ca_a), .misaligned_exception_out(mx_a), .state_out(st_a)
  );

  machine_trap_sequencer #(.FLUSH_CYCLES(3)) dut3 (
    .clk_in(clk), .rst_in(rst3),
    .illegal_instr_in(illegal), .misaligned_instr_in(mis_instr),
    .misaligned_load_in(mis_load), .misaligned_store_in(mis_store),
    .opcode_6_to_2_in(opcode), .funct3_in(funct3), .funct7_in(funct7),
    .rs1_adder_in(rs1), .rs2_adder_in(rs2), .rd_adder_in(rd),
    .mie_in(mie), .meie_in(meie), .mtie_in(mtie), .msie_in(msie),
    .eirq_in(eirq), .tirq_in(tirq), .sirq_in(sirq),
    .meip_in(meip), .mtip_in(mtip), .msip_in(msip),
    .pc_src_out(pc_b), .flush_out(fl_b), .trap_taken_out(tt_b),
    .set_epc_out(se_b), .set_cause_out(sc_b), .mie_clear_out(mc_b),
    .mie_set_out(ms_b), .instret_inc_out(ir_b), .i_or_e_out(ie_b),
    .cause_out(ca_b), .misaligned_exception_out(mx_b), .state_out(st_b)
  );

  assign obs_a = {pc_a, fl_a, tt_a, se_a, sc_a, mc_a, ms_a, ir_a, ie_a, ca_a, mx_a, 1'b0};
  assign obs_b = {pc_b, fl_b, tt_b, se_b, sc_b, mc_b, ms_b, ir_b, ie_b, ca_b, mx_b, 1'b0};

  // Expected output picture: flush/instret follow from the PC source, trap strobes move together.
  function automatic logic [15:0] snap(input logic [1:0] pc, input logic tr, input logic mset,
                                       input logic ie, input logic [3:0] c, input logic mis);
    snap = {pc, (pc != 2'b01), tr, tr, tr, tr, mset, (pc == 2'b01), ie, c, mis, 1'b0};
  endfunction

  task automatic clr();
    illegal = 0; mis_instr = 0; mis_load = 0; mis_store = 0;
    opcode = 0; rs1 = 0; rs2 = 0; rd = 0; funct3 = 0; funct7 = 0;
    mie = 0; meie = 0; mtie = 0; msie = 0; eirq = 0; tirq = 0; sirq = 0;
    meip = 0; mtip = 0; msip = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    clr();
  endtask

  task automatic chk(input string tag, input logic [15:0] e, input bit sel3);
    logic [15:0] o, x;
    exp_q.push_back(e);
    #1;
    o = sel3 ? obs_b : obs_a;
    x = exp_q.pop_front();
    vectors++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    clr();
    @(negedge clk);
    chk("reset_state", snap(2'b00, 0, 0, 0, 4'd0, 0), 0);
    rst = 0;
    chk("reset_hold_cycle", snap(2'b00, 0, 0, 0, 4'd0, 0), 0);
    cyc();                             chk("operating_idle", snap(2'b01, 0, 0, 0, 4'd0, 0), 0);
    illegal = 1;                       chk("illegal_strobe", snap(2'b01, 1, 0, 0, 4'd0, 0), 0);
    cyc(); illegal = 1;                chk("illegal_trap_ignore", snap(2'b10, 0, 0, 0, 4'd2, 0), 0);
    cyc();                             chk("back_operating", snap(2'b01, 0, 0, 0, 4'd2, 0), 0);
    cyc(); mie = 1; meie = 1; eirq = 1; illegal = 1;
                                       chk("irq_ill_strobe", snap(2'b01, 1, 0, 0, 4'd2, 0), 0);
    cyc();                             chk("irq_ill_cause", snap(2'b10, 0, 0, IRQ_EN, IRQ_EN ? 4'd11 : 4'd2, 0), 0);
    cyc();                             chk("irq_ill_hold", snap(2'b01, 0, 0, IRQ_EN, IRQ_EN ? 4'd11 : 4'd2, 0), 0);
    cyc(); opcode = 5'b11100;          chk("ecall_strobe", snap(2'b01, 1, 0, IRQ_EN, IRQ_EN ? 4'd11 : 4'd2, 0), 0);
    cyc();                             chk("ecall_cause", snap(2'b10, 0, 0, 0, 4'd11, 0), 0);
    cyc(); opcode = 5'b11100; rs2 = 5'd1;
                                       chk("ebreak_strobe", snap(2'b01, 1, 0, 0, 4'd11, 0), 0);
    cyc();                             chk("ebreak_cause", snap(2'b10, 0, 0, 0, 4'd3, 0), 0);
    cyc(); opcode = 5'b11100; rs2 = 5'd2; funct7 = 7'b0011000;
                                       chk("mret_strobe", snap(2'b01, 0, 1, 0, 4'd3, 0), 0);
    cyc();                             chk("mret_return", snap(2'b11, 0, 0, 0, 4'd3, 0), 0);
    cyc(); opcode = 5'b11100; rs2 = 5'd2; funct7 = 7'b0011000; illegal = 1;
                                       chk("mret_vs_trap", snap(2'b01, 1, 0, 0, 4'd3, 0), 0);
    cyc();                             chk("mret_vs_trap_cause", snap(2'b10, 0, 0, 0, 4'd2, 0), 0);
    cyc(); mis_store = 1; mis_load = 1;
                                       chk("mis_st_ld_strobe", snap(2'b01, 1, 0, 0, 4'd2, 0), 0);
    cyc();                             chk("mis_store_cause", snap(2'b10, 0, 0, 0, 4'd6, 1), 0);
    cyc(); mis_instr = 1; mis_load = 1;
                                       chk("mis_in_ld_strobe", snap(2'b01, 1, 0, 0, 4'd6, 0), 0);
    cyc();                             chk("mis_instr_cause", snap(2'b10, 0, 0, 0, 4'd0, 1), 0);
    cyc(); meie = 1; eirq = 1;         chk("irq_masked", snap(2'b01, 0, 0, 0, 4'd0, 0), 0);
    cyc(); mie = 1; msie = 1; sirq = 1; mtie = 1; tirq = 1;
                                       chk("sw_tim_strobe", snap(2'b01, IRQ_EN, 0, 0, 4'd0, 0), 0);
    cyc();                             chk("sw_tim_cause", snap(IRQ_EN ? 2'b10 : 2'b01, 0, 0, IRQ_EN, IRQ_EN ? 4'd3 : 4'd0, 0), 0);
    cyc();                             chk("sw_tim_hold", snap(2'b01, 0, 0, IRQ_EN, IRQ_EN ? 4'd3 : 4'd0, 0), 0);
    cyc(); illegal = 1; mis_instr = 1; chk("ill_mis_strobe", snap(2'b01, 1, 0, IRQ_EN, IRQ_EN ? 4'd3 : 4'd0, 0), 0);
    cyc();                             chk("ill_over_mis", snap(2'b10, 0, 0, 0, 4'd2, 1), 0);
    rst = 1;                           chk("async_reset_mid_trap", snap(2'b00, 0, 0, 0, 4'd0, 0), 0);
    cyc(); rst = 0;                    chk("reset_again", snap(2'b00, 0, 0, 0, 4'd0, 0), 0);
    cyc();                             chk("operating_again", snap(2'b01, 0, 0, 0, 4'd0, 0), 0);

    cyc(); rst3 = 0;                   chk("fc3_reset", snap(2'b00, 0, 0, 0, 4'd0, 0), 1);
    cyc();                             chk("fc3_operating", snap(2'b01, 0, 0, 0, 4'd0, 0), 1);
    cyc(); opcode = 5'b11100;          chk("fc3_ecall_strobe", snap(2'b01, 1, 0, 0, 4'd0, 0), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();                           chk($sformatf("fc3_flush_%0d", i), snap(2'b10, 0, 0, 0, 4'd11, 0), 1);
    end
    cyc();                             chk("fc3_back_operating", snap(2'b01, 0, 0, 0, 4'd11, 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
